// File: rtl/des_sbox_stage.sv
// des_sbox_stage: iterative DES S-box substitution stage.
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   e_in, subkey     : 48-bit expanded half-block and round subkey (DES bit 1 at [47])
//   in_valid/in_ready: operand handshake, accepted only in IDLE
//   s_out            : 32-bit result, S1 at [31:28] .. S8 at [3:0]
//   out_valid/ready  : result handshake, s_out held stable while out_valid && !out_ready
//   busy             : high while S-box lookups are in progress
// SBOX_PER_CYCLE (1, 2, 4, 8) boxes are evaluated per clock; latency is 8/SBOX_PER_CYCLE.
module des_sbox_stage #(
  parameter int SBOX_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] e_in,
  input  logic [47:0] subkey,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] s_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  if (!(SBOX_PER_CYCLE == 1 || SBOX_PER_CYCLE == 2 ||
        SBOX_PER_CYCLE == 4 || SBOX_PER_CYCLE == 8)) begin : g_bad_param
    $error("des_sbox_stage: SBOX_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int N  = 8 / SBOX_PER_CYCLE;
  localparam int GW = 4 * SBOX_PER_CYCLE;
  localparam logic [2:0] CNT_LAST = 3'(N - 1);

  // Each table is 64 nibbles, row 0 col 0 in the top nibble, indexed by row*16+col.
  localparam logic [255:0] SBOX [8] = '{
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] b);
    logic [5:0] idx;
    idx = {b[5], b[0], b[4:1]};
    return SBOX[box][255 - 4*idx -: 4];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nx;
  logic [47:0] sreg;
  logic [31:0] acc;
  logic [31:0] acc_nx;
  logic [2:0]  cnt;
  logic [GW-1:0] grp;

  // Topmost chunk feeds the lowest-numbered pending box and lands in the upper nibble of grp.
  always_comb begin
    grp = '0;
    for (int unsigned i = 0; i < SBOX_PER_CYCLE; i++) begin
      grp[GW-4-4*i +: 4] = sbox_lookup(3'(cnt * 3'(SBOX_PER_CYCLE) + 3'(i)), sreg[47-6*i -: 6]);
    end
  end

  // Shift by the full width clears acc when all eight boxes run in one cycle.
  assign acc_nx = (acc << GW) | 32'(grp);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // s_out is a separate register so the previous result survives the accumulator clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg  <= '0;
      acc   <= '0;
      cnt   <= '0;
      s_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg <= e_in ^ subkey;
            acc  <= '0;
            cnt  <= '0;
          end
        end
        BUSY: begin
          sreg <= sreg << (6 * SBOX_PER_CYCLE);
          acc  <= acc_nx;
          cnt  <= cnt + 3'd1;
          if (cnt == CNT_LAST) s_out <= acc_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_sbox_stage.sv
module tb_des_sbox_stage;

  typedef struct {
    logic [47:0] e;
    logic [47:0] k;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [47:0] e_in, subkey;
  logic in_valid, out_ready;
  logic [3:0] in_ready, out_valid, busy;
  logic [3:0][31:0] s_out;

  int n_checks = 0;
  int n_fail = 0;
  localparam int NLAT [4] = '{8, 4, 2, 1};
  logic [31:0] sbq [4][$];
  vec_t vecs [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    des_sbox_stage #(.SBOX_PER_CYCLE(1 << g)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .e_in     (e_in),
      .subkey   (subkey),
      .in_valid (in_valid),
      .in_ready (in_ready[g]),
      .s_out    (s_out[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready),
      .busy     (busy[g])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop one expected result per output handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < 4; g++) begin
        if (out_valid[g] && out_ready) begin
          if (sbq[g].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_output spc=%0d: got %0h expected none", 1 << g, s_out[g]);
          end else begin
            check($sformatf("s_out spc=%0d", 1 << g), 64'(s_out[g]), 64'(sbq[g].pop_front()));
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 64'(in_ready), 64'hF);
    check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    for (int g = 0; g < 4; g++) check($sformatf("%s_s_out%0d", tag, g), 64'(s_out[g]), 64'h0);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat [4];
    @(posedge clk); #2;
    e_in = v.e; subkey = v.k; in_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      sbq[g].push_back(v.exp);
      lat[g] = 99;
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    e_in = {16'($urandom), $urandom};
    subkey = {16'($urandom), $urandom};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int g = 0; g < 4; g++) if (out_valid[g] && lat[g] == 99) lat[g] = k;
    end
    for (int g = 0; g < 4; g++)
      check($sformatf("%s_latency spc=%0d", tag, 1 << g), 64'(lat[g]), 64'(NLAT[g]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat0;
    int cd [4];
    logic seen;
    vecs[0] = '{48'h0, 48'h0, 32'hEFA72C4D};
    vecs[1] = '{48'hFFFFFFFFFFFF, 48'h0, 32'hD9CE3DCB};
    vecs[2] = '{48'h0, 48'hFFFFFFFFFFFF, 32'hD9CE3DCB};
    vecs[3] = '{48'h7A15557A1555, 48'h1B02EFFC7072, 32'h5C82B597};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; e_in = '0; subkey = '0;
    #1;
    check_reset_vals("reset_initial");
    #20;
    @(posedge clk); #2;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Abort mid-computation: large-N instances are still busy after three edges.
    @(posedge clk); #2;
    e_in = vecs[3].e; subkey = vecs[3].k; in_valid = 1'b1;
    sbq[2].push_back(vecs[3].exp);
    sbq[3].push_back(vecs[3].exp);
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy0", 64'(busy[0]), 64'h1);
    check("abort_in_ready0", 64'(in_ready[0]), 64'h0);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("reset_busy");
    @(posedge clk); #2;
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid != 4'h0) seen = 1'b1;
    end
    check("abort_no_output", 64'(seen), 64'h0);

    // Backpressure
    out_ready = 1'b0;
    @(posedge clk); #2;
    e_in = vecs[3].e; subkey = vecs[3].k; in_valid = 1'b1;
    for (int g = 0; g < 4; g++) sbq[g].push_back(vecs[3].exp);
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat0 = 99;
    for (int k = 0; k < 12 && lat0 == 99; k++) begin
      @(negedge clk);
      if (out_valid[0]) lat0 = k;
    end
    check("bp_latency", 64'(lat0), 64'(NLAT[0]));
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #2;
      e_in = vecs[1].e; subkey = vecs[1].k; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'hF);
      check($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'h0);
      for (int g = 0; g < 4; g++)
        check($sformatf("bp_s_out_c%0d_spc%0d", c, 1 << g), 64'(s_out[g]), 64'(vecs[3].exp));
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_release_out_valid", 64'(out_valid), 64'h0);
    check("bp_release_in_ready", 64'(in_ready), 64'hF);

    // Back-to-back with in_valid held high; operands change every cycle.
    for (int g = 0; g < 4; g++) cd[g] = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge clk); #2;
      e_in = vecs[cyc % 4].e; subkey = vecs[cyc % 4].k; in_valid = 1'b1;
      for (int g = 0; g < 4; g++) begin
        check($sformatf("b2b_ready_cyc%0d_spc%0d", cyc, 1 << g), 64'(in_ready[g]), 64'(cd[g] == 0));
        if (cd[g] == 0) begin
          sbq[g].push_back(vecs[cyc % 4].exp);
          cd[g] = NLAT[g] + 1;
        end else begin
          cd[g]--;
        end
      end
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (14) @(negedge clk);

    for (int g = 0; g < 4; g++)
      check($sformatf("drained spc=%0d", 1 << g), 64'(sbq[g].size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
